// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu_pkg : shared encodings and helpers for the load/store unit       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_LILLEGAL = 3'b111;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic [7:0] size_from_funct3(input logic [2:0] funct3);
        return 8'd1 << funct3[1:0];
    endfunction

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        return ~(3'b111 << funct3[1:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu_align : load lane select by byte offset, truncate and extend     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rd_data,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] lane;
    logic            zext;

    assign lane = rd_data >> {offset, 3'b000};
    assign zext = funct3[2];

    always_comb begin
        load_data = lane;
        case (funct3[1:0])
            SZ_B: load_data = {{(XLEN-8){~zext & lane[7]}},   lane[7:0]};
            SZ_H: load_data = {{(XLEN-16){~zext & lane[15]}}, lane[15:0]};
            SZ_W: load_data = {{(XLEN-32){~zext & lane[31]}}, lane[31:0]};
            default: load_data = lane;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu : multi-cycle load/store unit in front of the DPI memory block   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int XLEN    = 64
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iReqValid,
    output logic            oReqReady,
    input  logic            iReqWrite,
    input  logic [XLEN-1:0] iReqAddr,
    input  logic [XLEN-1:0] iReqWrData,
    input  logic [2:0]      iReqFunct3,
    output logic            oRespValid,
    input  logic            iRespReady,
    output logic [XLEN-1:0] oRespData,
    output logic            oRespErr,
    output logic [XLEN-1:0] oMemRdAddrLoad,
    input  logic [XLEN-1:0] iMemRdDataLoad,
    output logic            oMemWrEn,
    output logic [XLEN-1:0] oMemWrAddr,
    output logic [XLEN-1:0] oMemWrData,
    output logic [7:0]      oMemWrLen
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST =
        LAT_CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t                 state, state_next;
    logic                   req_write;
    logic [2:0]             req_offset;
    logic [2:0]             req_funct3;
    logic [LAT_CNT_W-1:0]   wait_cnt;
    logic                   resp_valid;
    logic                   resp_err;
    logic [XLEN-1:0]        resp_data;
    logic [XLEN-1:0]        rd_addr;
    logic                   wr_en;
    logic [XLEN-1:0]        wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [7:0]             wr_len;

    logic                   in_illegal;
    logic                   in_misaligned;
    logic                   in_ok;
    logic [XLEN-1:0]        in_wr_masked;
    logic [XLEN-1:0]        load_ext;
    logic                   capture;

    assign in_illegal    = iReqWrite ? iReqFunct3[2] : (iReqFunct3 == F3_LILLEGAL);
    assign in_misaligned = (iReqAddr[2:0] & align_mask(iReqFunct3)) != 3'd0;
    assign in_ok         = ~in_illegal & ~in_misaligned;

    always_comb begin
        in_wr_masked = iReqWrData;
        case (iReqFunct3[1:0])
            SZ_B: in_wr_masked = {{(XLEN-8){1'b0}},  iReqWrData[7:0]};
            SZ_H: in_wr_masked = {{(XLEN-16){1'b0}}, iReqWrData[15:0]};
            SZ_W: in_wr_masked = {{(XLEN-32){1'b0}}, iReqWrData[31:0]};
            default: in_wr_masked = iReqWrData;
        endcase
    end

    mem_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .rd_data   (iMemRdDataLoad),
        .offset    (req_offset),
        .funct3    (req_funct3),
        .load_data (load_ext)
    );

    // Load data is sampled on the edge that leaves the final ACCESS/WAIT cycle.
    assign capture = ~req_write &&
                     (((state == ACCESS) && (LATENCY == 0)) ||
                      ((state == WAIT) && (wait_cnt == LAT_LAST)));

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iReqValid) state_next = in_ok ? ACCESS : RESP;
            ACCESS:  state_next = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == LAT_LAST) state_next = RESP;
            RESP:    if (resp_valid && iRespReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            req_write  <= 1'b0;
            req_offset <= 3'd0;
            req_funct3 <= 3'd0;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_len     <= 8'd0;
        end else begin
            // Store port idles at zero so repeated identical stores still toggle.
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_len  <= 8'd0;
            case (state)
                IDLE: begin
                    if (iReqValid) begin
                        req_write  <= iReqWrite;
                        req_offset <= iReqAddr[2:0];
                        req_funct3 <= iReqFunct3;
                        resp_data  <= '0;
                        resp_err   <= ~in_ok;
                        if (in_ok && iReqWrite) begin
                            wr_en   <= 1'b1;
                            wr_addr <= iReqAddr;
                            wr_data <= in_wr_masked;
                            wr_len  <= size_from_funct3(iReqFunct3);
                        end else if (in_ok) begin
                            rd_addr <= {iReqAddr[XLEN-1:3], 3'b000};
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= '0;
                    if (capture) resp_data <= load_ext;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + LAT_CNT_W'(1);
                    if (capture) resp_data <= load_ext;
                end
                RESP: begin
                    // Valid rises one cycle after entering RESP and drops on handshake.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (iRespReady) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_data  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReqReady      = (state == IDLE);
    assign oRespValid     = resp_valid;
    assign oRespErr       = resp_err;
    assign oRespData      = resp_data;
    assign oMemRdAddrLoad = rd_addr;
    assign oMemWrEn       = wr_en;
    assign oMemWrAddr     = wr_addr;
    assign oMemWrData     = wr_data;
    assign oMemWrLen      = wr_len;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_lsu : bench for mem_lsu, LATENCY=0 and LATENCY=3 instances        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_f3;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [1:0]  wr_en;
    logic [63:0] resp_data_a [2];
    logic [63:0] rd_addr_a   [2];
    logic [63:0] rd_data_a   [2];
    logic [63:0] wr_addr_a   [2];
    logic [63:0] wr_data_a   [2];
    logic [7:0]  wr_len_a    [2];

    mem_lsu #(.LATENCY(0), .XLEN(64)) dut0 (
        .iClock(clk), .iReset(rst_n[0]),
        .iReqValid(req_valid[0]), .oReqReady(req_ready[0]),
        .iReqWrite(req_write), .iReqAddr(req_addr), .iReqWrData(req_wdata), .iReqFunct3(req_f3),
        .oRespValid(resp_valid[0]), .iRespReady(resp_ready[0]),
        .oRespData(resp_data_a[0]), .oRespErr(resp_err[0]),
        .oMemRdAddrLoad(rd_addr_a[0]), .iMemRdDataLoad(rd_data_a[0]),
        .oMemWrEn(wr_en[0]), .oMemWrAddr(wr_addr_a[0]), .oMemWrData(wr_data_a[0]), .oMemWrLen(wr_len_a[0])
    );

    mem_lsu #(.LATENCY(3), .XLEN(64)) dut3 (
        .iClock(clk), .iReset(rst_n[1]),
        .iReqValid(req_valid[1]), .oReqReady(req_ready[1]),
        .iReqWrite(req_write), .iReqAddr(req_addr), .iReqWrData(req_wdata), .iReqFunct3(req_f3),
        .oRespValid(resp_valid[1]), .iRespReady(resp_ready[1]),
        .oRespData(resp_data_a[1]), .oRespErr(resp_err[1]),
        .oMemRdAddrLoad(rd_addr_a[1]), .iMemRdDataLoad(rd_data_a[1]),
        .oMemWrEn(wr_en[1]), .oMemWrAddr(wr_addr_a[1]), .oMemWrData(wr_data_a[1]), .oMemWrLen(wr_len_a[1])
    );

    // Shared memory stand-in: 2 KiB at 0x80000000, written by the store strobes.
    logic [63:0] mem [256];
    logic        mem_clr;
    int          strobe_cnt [2];
    int          idle_nonzero;

    assign rd_data_a[0] = mem[rd_addr_a[0][10:3]];
    assign rd_data_a[1] = mem[rd_addr_a[1][10:3]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
            strobe_cnt[0] <= 0;
            strobe_cnt[1] <= 0;
            idle_nonzero  <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    strobe_cnt[i] <= strobe_cnt[i] + 1;
                    for (int b = 0; b < 8; b++) begin
                        if (b < int'(wr_len_a[i]) && (int'(wr_addr_a[i][2:0]) + b) < 8)
                            mem[wr_addr_a[i][10:3]][(int'(wr_addr_a[i][2:0]) + b) * 8 +: 8] <= wr_data_a[i][b*8 +: 8];
                    end
                end else if (wr_addr_a[i] != 64'd0 || wr_data_a[i] != 64'd0 || wr_len_a[i] != 8'd0) begin
                    idle_nonzero <= idle_nonzero + 1;
                end
            end
        end
    end

    int tests;
    int fails;
    logic [7:0]  ref_bytes [2048];
    logic [63:0] exp_rd [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian assembly, explicit extension.
    task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [2:0] f3,
                         output logic [63:0] e_data, output logic e_err);
        int size;
        int off;
        logic [63:0] v;
        size   = 1 << f3[1:0];
        off    = int'(a[10:0]);
        e_err  = (w ? f3[2] : (f3 == 3'b111)) || ((int'(a[2:0]) % size) != 0);
        e_data = 64'd0;
        if (!e_err) begin
            if (w) begin
                for (int b = 0; b < size; b++) ref_bytes[off + b] = d[8*b +: 8];
            end else begin
                v = 64'd0;
                for (int b = 0; b < size; b++) v = v | (64'(ref_bytes[off + b]) << (8*b));
                if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
                e_data = v;
            end
        end
    endtask

    task automatic run_txn(input int sel, input logic w, input logic [63:0] a, input logic [63:0] d,
                           input logic [2:0] f3,
                           output logic [63:0] r_data, output logic r_err, output int lat, output int strobes,
                           output logic s_en, output logic [63:0] s_addr, output logic [63:0] s_data,
                           output logic [7:0] s_len, output logic [63:0] e_data, output logic e_err);
        int c0;
        model(w, a, d, f3, e_data, e_err);
        c0 = strobe_cnt[sel];
        req_write = w; req_addr = a; req_wdata = d; req_f3 = f3;
        req_valid[sel] = 1'b1;
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
        req_write = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom}; req_f3 = 3'($urandom);
        s_en = wr_en[sel]; s_addr = wr_addr_a[sel]; s_data = wr_data_a[sel]; s_len = wr_len_a[sel];
        lat = 0;
        while (!resp_valid[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r_data = resp_data_a[sel];
        r_err  = resp_err[sel];
        resp_ready[sel] = 1'b1;
        @(posedge clk); #1;
        resp_ready[sel] = 1'b0;
        strobes = strobe_cnt[sel] - c0;
        if (!w && !e_err) exp_rd[sel] = {a[63:3], 3'b000};
    endtask

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [2:0]  f3;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [63:0] r_data, s_addr, s_data, e_data;
        logic        r_err, s_en, e_err;
        logic [7:0]  s_len;
        int          lat, strobes, bad, c0;
        logic [63:0] held;

        tests = 0; fails = 0;
        for (int i = 0; i < 2048; i++) ref_bytes[i] = 8'd0;
        exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
        rst_n = 2'b00; req_valid = 2'b00; resp_ready = 2'b00; mem_clr = 1'b1;
        req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_f3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_data", resp_data_a[0] | resp_data_a[1], 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_fields", wr_addr_a[0] | wr_data_a[0] | 64'(wr_len_a[0]), 64'd0);
        check("rst_rd_addr", rd_addr_a[0] | rd_addr_a[1], 64'd0);
        rst_n = 2'b11; mem_clr = 1'b0;
        @(posedge clk); #1;

        // Preload the doubleword used by the directed loads.
        run_txn(0, 1'b1, 64'h8000_0000, 64'h8877_6655_4433_2211, 3'b011,
                r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
        check("sd_strobe_cnt", 64'(strobes), 64'd1);
        check("sd_len", 64'(s_len), 64'd8);
        check("sd_data", s_data, 64'h8877_6655_4433_2211);

        vecs[0]  = '{1'b0, 64'h8000_0007, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
        vecs[1]  = '{1'b0, 64'h8000_0006, 3'b101, 64'h0000_0000_0000_8877, 1'b0};
        vecs[2]  = '{1'b0, 64'h8000_0004, 3'b010, 64'hFFFF_FFFF_8877_6655, 1'b0};
        vecs[3]  = '{1'b0, 64'h8000_0000, 3'b011, 64'h8877_6655_4433_2211, 1'b0};
        vecs[4]  = '{1'b0, 64'h8000_0007, 3'b100, 64'h0000_0000_0000_0088, 1'b0};
        vecs[5]  = '{1'b0, 64'h8000_0004, 3'b110, 64'h0000_0000_8877_6655, 1'b0};
        vecs[6]  = '{1'b0, 64'h8000_0002, 3'b001, 64'h0000_0000_0000_4433, 1'b0};
        vecs[7]  = '{1'b0, 64'h8000_0001, 3'b001, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, 64'h8000_0000, 3'b111, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, 64'h8000_0000, 3'b100, 64'h0, 1'b1};
        vecs[10] = '{1'b1, 64'h8000_0004, 3'b011, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 64'h8000_0002, 3'b010, 64'h0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            held = exp_rd[0];
            run_txn(0, vecs[i].w, vecs[i].addr, {$urandom, $urandom}, vecs[i].f3,
                    r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
            check($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 64'(r_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].exp_err ? 64'd1 : 64'd2);
            check($sformatf("vec%0d_strobes", i), 64'(strobes), 64'd0);
            check($sformatf("vec%0d_rd_addr", i), rd_addr_a[0],
                  vecs[i].exp_err ? held : {vecs[i].addr[63:3], 3'b000});
        end

        // Word store, then the identical store twice back to back.
        for (int k = 0; k < 3; k++) begin
            run_txn(0, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 3'b010,
                    r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
            check("sw_strobe_en", 64'(s_en), 64'd1);
            check("sw_addr", s_addr, 64'h8000_0010);
            check("sw_data", s_data, 64'h0000_0000_CAFE_F00D);
            check("sw_len", 64'(s_len), 64'd4);
            check("sw_strobe_cnt", 64'(strobes), 64'd1);
            check("sw_resp", r_data | 64'(r_err), 64'd0);
            check("sw_latency", 64'(lat), 64'd2);
        end
        run_txn(0, 1'b0, 64'h8000_0010, 64'd0, 3'b010,
                r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
        check("lw_after_sw", r_data, 64'hFFFF_FFFF_CAFE_F00D);

        // LATENCY=3 instance: store then load with backpressure.
        run_txn(1, 1'b1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 3'b011,
                r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
        check("l3_sd_latency", 64'(lat), 64'd5);
        check("l3_sd_strobes", 64'(strobes), 64'd1);

        model(1'b0, 64'h8000_0008, 64'd0, 3'b011, e_data, e_err);
        req_write = 1'b0; req_addr = 64'h8000_0008; req_f3 = 3'b011;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        lat = 0; bad = 0;
        while (!resp_valid[1] && lat < 40) begin
            if (rd_addr_a[1] !== 64'h8000_0008) bad++;
            @(posedge clk); #1;
            lat++;
        end
        exp_rd[1] = 64'h8000_0008;
        check("l3_ld_latency", 64'(lat), 64'd5);
        check("l3_rd_addr_hold", 64'(bad), 64'd0);
        check("l3_ld_data", resp_data_a[1], 64'h0123_4567_89AB_CDEF);
        c0 = strobe_cnt[1];
        req_write = 1'b1; req_addr = 64'h8000_0100; req_wdata = 64'h55; req_f3 = 3'b000;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid[1]), 64'd1);
            check("hold_data", resp_data_a[1], 64'h0123_4567_89AB_CDEF);
            check("hold_req_ready", 64'(req_ready[1]), 64'd0);
        end
        req_valid[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid[1]) bad++;
        end
        check("ignored_req_no_resp", 64'(bad), 64'd0);
        check("ignored_req_no_strobe", 64'(strobe_cnt[1] - c0), 64'd0);

        // Reset while the load sits in WAIT.
        req_write = 1'b0; req_addr = 64'h8000_0008; req_f3 = 3'b011;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        exp_rd[1] = 64'd0;
        check("abort_req_ready", 64'(req_ready[1]), 64'd1);
        check("abort_resp_valid", 64'(resp_valid[1]), 64'd0);
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid[1]) bad++;
        end
        check("abort_no_resp", 64'(bad), 64'd0);
        run_txn(1, 1'b0, 64'h8000_0000, 64'd0, 3'b011,
                r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
        check("post_abort_data", r_data, 64'h8877_6655_4433_2211);
        check("post_abort_latency", 64'(lat), 64'd5);

        // Randomized traffic against the byte-level reference model.
        for (int n = 0; n < 160; n++) begin
            int          sel, size, off;
            logic        w;
            logic [2:0]  f3;
            logic [63:0] a, d;
            sel  = int'($urandom_range(0, 1));
            w    = 1'($urandom);
            f3   = 3'($urandom);
            size = 1 << f3[1:0];
            off  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) off = off & ~(size - 1);
            a = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd8 + 64'(off);
            d = {$urandom, $urandom};
            run_txn(sel, w, a, d, f3,
                    r_data, r_err, lat, strobes, s_en, s_addr, s_data, s_len, e_data, e_err);
            check($sformatf("rnd%0d_data", n), r_data, e_data);
            check($sformatf("rnd%0d_err", n), 64'(r_err), 64'(e_err));
            check($sformatf("rnd%0d_latency", n), 64'(lat),
                  e_err ? 64'd1 : ((sel == 0) ? 64'd2 : 64'd5));
            check($sformatf("rnd%0d_strobes", n), 64'(strobes), (w && !e_err) ? 64'd1 : 64'd0);
            check($sformatf("rnd%0d_rd_addr", n), rd_addr_a[sel], exp_rd[sel]);
            if (w && !e_err) begin
                check($sformatf("rnd%0d_wr_data", n), s_data,
                      (size == 8) ? d : (d & ((64'd1 << (8*size)) - 64'd1)));
                check($sformatf("rnd%0d_wr_len", n), 64'(s_len), 64'(size));
                check($sformatf("rnd%0d_wr_addr", n), s_addr, a);
            end
        end

        check("store_port_idle_zero", 64'(idle_nonzero), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
